// File: rtl/itlb_ptw.sv
// itlb_ptw -- Sv32 hardware page-table walker for ITLB misses.
//
// Accepts one ITLB miss at a time. It walks the two-level Sv32 page table
// through a single-outstanding PTE read port. The walk ends in one of two
// ways:
//   - a one-cycle ITLB refill strobe, or
//   - an instruction page fault / access fault returned to fetch.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   req_*                 miss request (valid/ready), vaddr, asid, privilege mode
//   satp_ppn_i            root page-table PPN, captured with the request
//   flush_i               sfence.vma: abandon the walk, never respond
//   mem_req_*             PTE read request (valid/ready) and physical address
//   mem_resp_*            PTE read data, bus error flag
//   refill_*              ITLB write port (1-cycle strobe plus entry fields)
//   resp_*                walk completion (1 cycle) with fault classification
module itlb_ptw #(
  parameter int VADDR_WD = 32,
  parameter int PADDR_WD = 34,
  parameter int ASID_WD  = 9,
  parameter int PTE_WD   = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [VADDR_WD-1:0] req_vaddr_i,
  input  logic [ASID_WD-1:0]  req_asid_i,
  input  logic [1:0]          req_mode_i,
  input  logic [21:0]         satp_ppn_i,
  input  logic                flush_i,
  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic [PADDR_WD-1:0] mem_req_addr_o,
  input  logic                mem_resp_valid_i,
  input  logic [PTE_WD-1:0]   mem_resp_data_i,
  input  logic                mem_resp_err_i,
  output logic                refill_we_o,
  output logic [19:0]         refill_vpn_o,
  output logic [ASID_WD-1:0]  refill_asid_o,
  output logic [21:0]         refill_ppn_o,
  output logic [7:0]          refill_flags_o,
  output logic                refill_super_o,
  output logic                resp_valid_o,
  output logic                resp_page_fault_o,
  output logic                resp_access_fault_o
);

  localparam logic [1:0] MODE_U = 2'b00;
  localparam logic [1:0] MODE_S = 2'b01;

  typedef enum logic [2:0] {
    IDLE,
    L1_REQ,
    L1_WAIT,
    L0_REQ,
    L0_WAIT,
    DONE,
    DRAIN
  } state_e;

  state_e state_q, state_d;

  // Captured request and walk results
  logic [19:0]         vpn_q;
  logic [ASID_WD-1:0]  asid_q;
  logic [1:0]          mode_q;
  logic [21:0]         satp_q;
  logic [21:0]         ptr_ppn_q;   // next-level table from an L1 pointer PTE
  logic [21:0]         leaf_ppn_q;
  logic [7:0]          leaf_flags_q;
  logic                super_q;
  logic                pf_q;
  logic                af_q;

  // PTE field decode
  logic [21:0] pte_ppn;
  logic        pte_v, pte_r, pte_w, pte_x, pte_u, pte_a;

  assign pte_ppn = mem_resp_data_i[31:10];
  assign pte_v   = mem_resp_data_i[0];
  assign pte_r   = mem_resp_data_i[1];
  assign pte_w   = mem_resp_data_i[2];
  assign pte_x   = mem_resp_data_i[3];
  assign pte_u   = mem_resp_data_i[4];
  assign pte_a   = mem_resp_data_i[6];

  // Page-offset bits and the RSW field never influence the walk
  logic unused_bits;
  assign unused_bits = ^{req_vaddr_i[11:0], mem_resp_data_i[9:8]};

  // PTE addresses. Unsigned PADDR_WD-bit sums; any carry out is dropped.
  logic [PADDR_WD-1:0] l1_addr, l0_addr;
  assign l1_addr = PADDR_WD'({satp_q, 12'h000})    + PADDR_WD'({vpn_q[19:10], 2'b00});
  assign l0_addr = PADDR_WD'({ptr_ppn_q, 12'h000}) + PADDR_WD'({vpn_q[9:0], 2'b00});

  logic in_wait;
  assign in_wait = (state_q == L1_WAIT) || (state_q == L0_WAIT);

  // Classify the PTE arriving in either WAIT state
  logic walk_pf, walk_af, walk_ptr, leaf_fault;

  // NOTE: every signal written in an always_comb gets a default first.
  // A path that leaves one unassigned infers a latch.
  always_comb begin
    walk_pf    = 1'b0;
    walk_af    = 1'b0;
    walk_ptr   = 1'b0;
    leaf_fault = !pte_x || !pte_a
              || (mode_q == MODE_U && !pte_u)
              || (mode_q == MODE_S &&  pte_u)
              || (state_q == L1_WAIT && pte_ppn[9:0] != 10'd0);
    if (mem_resp_err_i) begin
      walk_af = 1'b1;
    end else if (!pte_v || (!pte_r && pte_w)) begin
      walk_pf = 1'b1;
    end else if (!pte_r && !pte_x) begin
      // Pointer PTE: legal at L1 only, since Sv32 has just two levels
      if (state_q == L1_WAIT) walk_ptr = 1'b1;
      else                    walk_pf  = 1'b1;
    end else begin
      walk_pf = leaf_fault;
    end
  end

  // Next state and outputs
  always_comb begin
    state_d             = state_q;
    req_ready_o         = 1'b0;
    mem_req_valid_o     = 1'b0;
    mem_req_addr_o      = '0;
    resp_valid_o        = 1'b0;
    resp_page_fault_o   = 1'b0;
    resp_access_fault_o = 1'b0;
    refill_we_o         = 1'b0;
    refill_vpn_o        = '0;
    refill_asid_o       = '0;
    refill_ppn_o        = '0;
    refill_flags_o      = '0;
    refill_super_o      = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i && !flush_i) state_d = L1_REQ;
      end

      L1_REQ, L0_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_req_addr_o  = (state_q == L1_REQ) ? l1_addr : l0_addr;
        if (mem_req_ready_i) begin
          // A read accepted in the flush cycle still returns data; drain it
          if (flush_i)                    state_d = DRAIN;
          else if (state_q == L1_REQ)     state_d = L1_WAIT;
          else                            state_d = L0_WAIT;
        end else if (flush_i) begin
          state_d = IDLE;
        end
      end

      L1_WAIT, L0_WAIT: begin
        if (mem_resp_valid_i) begin
          // Flush in the same cycle as the response: the response is consumed
          // here, so there is nothing left to drain.
          if (flush_i)       state_d = IDLE;
          else if (walk_ptr) state_d = L0_REQ;
          else               state_d = DONE;
        end else if (flush_i) begin
          state_d = DRAIN;
        end
      end

      DONE: begin
        state_d = IDLE;
        if (!flush_i) begin
          resp_valid_o        = 1'b1;
          resp_page_fault_o   = pf_q;
          resp_access_fault_o = af_q;
          if (!pf_q && !af_q) begin
            refill_we_o    = 1'b1;
            refill_vpn_o   = vpn_q;
            refill_asid_o  = asid_q;
            refill_ppn_o   = {leaf_ppn_q[21:10], super_q ? 10'd0 : leaf_ppn_q[9:0]};
            refill_flags_o = leaf_flags_q;
            refill_super_o = super_q;
          end
        end
      end

      DRAIN: begin
        if (mem_resp_valid_i) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. Every flop
  // then samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: the capture registers are reset along with the FSM. A walk restarted
  // after reset then never sees stale fields, and the refill bus reads zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vpn_q        <= '0;
      asid_q       <= '0;
      mode_q       <= '0;
      satp_q       <= '0;
      ptr_ppn_q    <= '0;
      leaf_ppn_q   <= '0;
      leaf_flags_q <= '0;
      super_q      <= 1'b0;
      pf_q         <= 1'b0;
      af_q         <= 1'b0;
    end else begin
      if (state_q == IDLE && req_valid_i && !flush_i) begin
        vpn_q  <= req_vaddr_i[31:12];
        asid_q <= req_asid_i;
        mode_q <= req_mode_i;
        satp_q <= satp_ppn_i;
        pf_q   <= 1'b0;
        af_q   <= 1'b0;
      end
      if (in_wait && mem_resp_valid_i) begin
        pf_q         <= walk_pf;
        af_q         <= walk_af;
        leaf_ppn_q   <= pte_ppn;
        leaf_flags_q <= mem_resp_data_i[7:0];
        super_q      <= (state_q == L1_WAIT);
        if (walk_ptr) ptr_ppn_q <= pte_ppn;
      end
    end
  end

endmodule
